idct_block_writer: RTL and testbench
====================================

// Module: idct_block_writer
// PURPOSE
//  Write-back end of the Milestone 2 IDCT datapath. After the IDCT core finishes
//  one 8x8 block, it leaves 64 signed 32-bit results in a dual-port RAM. This block
//  reads them, scales and clips each to 8 bits, and packs two pixels per 16-bit word.
//  It writes 32 words to the post-IDCT Y/U/V region of external SRAM.
// PARAMETERS
//  SHIFT       16      arithmetic right shift applied to each IDCT result before clipping
//  Y_BASE      0       SRAM word address of Y plane
//  U_BASE      38400   SRAM word address of U plane
//  V_BASE      57600   SRAM word address of V plane
//  Y_STRIDE    160     SRAM words per Y pixel row
//  UV_STRIDE   80      SRAM words per U/V pixel row
// PORTS
//  Clock            in   1   system clock, all logic on rising edge
//  Resetn           in   1   asynchronous, active-low reset
//  start            in   1   one-cycle request to write one block; sampled only in IDLE
//  plane            in   2   0=Y, 1=U, 2=V, 3 treated as V
//  block_row        in   5   block row index (0..29)
//  block_col        in   6   block column index (Y 0..39, U/V 0..19)
//  busy             out  1   high from the cycle after start is accepted until done
//  done             out  1   one-cycle pulse after the last SRAM write
//  DP_address_a     out  6   RAM port A read address (even sample), registered
//  DP_address_b     out  6   RAM port B read address (odd sample), registered
//  DP_read_data_a   in   32  port A data, valid 1 cycle after address
//  DP_read_data_b   in   32  port B data, valid 1 cycle after address
//  SRAM_address     out  18  SRAM word address, registered
//  SRAM_write_data  out  16  {even pixel[15:8], odd pixel[7:0]}, registered
//  SRAM_we_n        out  1   SRAM write enable, active low, registered
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0,
//    DP addresses=0, word counter k=0.
//  - FSM: IDLE -> LI0 -> LI1 -> WRITE (32 cycles) -> DONE -> IDLE.
//    * IDLE: on start=1, latch plane, block_row and block_col, then go to LI0.
//    * LI0: issue read addresses pair 0 (a=0, b=1).
//    * LI1: issue pair 1; pair 0 data arrives.
//    * WRITE: one SRAM write per cycle for k=0..31; issue pair k+2 while k+2<32.
//    * DONE: SRAM_we_n=1, done=1 for one cycle, then return to IDLE.
//  - Timing: the first SRAM_we_n low is the 3rd cycle after the start edge. The last
//    write is 34 cycles after start, and done pulses 35 cycles after start.
//  - Word k: row r=k>>2, quad q=k&3. Samples used are 8r+2q (even) and 8r+2q+1 (odd).
//  - Address: BASE(plane) + (8*block_row + r)*STRIDE(plane) + 4*block_col + q,
//    computed modulo 2^18. Block coordinates are not range-checked.
//  - Pixel: v = data >>> SHIFT (sign preserved).
//    * If v<0, pixel=8'h00.
//    * If v>255, pixel=8'hFF.
//    * Otherwise pixel=v[7:0].
//  - A start asserted while busy or in DONE is ignored; it is not queued.
//  - Outside WRITE, SRAM_we_n stays 1 and SRAM_write_data holds its last value.
//  - Reset mid-operation: all outputs go to their reset values immediately and no
//    further writes occur. The next start behaves as from power-up.
//  - The RAM ports are read-only from this block; the IDCT core must not overwrite
//    the RAM from start until done.
// CONFIGURATION
//  IDCT_WR_CLIP_COUNT_EN defined:
//   - Adds output clip_count [6:0]: the number of samples clipped (low or high) in
//     the current block.
//   - The count clears when start is accepted and is valid, holding its value, from
//     done until the next start.
//  IDCT_WR_CLIP_COUNT_EN not defined: the port and counter are absent; behaviour is
//   otherwise identical.
// TESTING
//  1 Y block (0,0), RAM[n]=n<<16 -> SRAM[0]=16'h0001, [1]=16'h0203, [3]=16'h0607,
//    [160]=16'h0809, [1123]=16'h3E3F; exactly 32 writes.
//  2 U block row=1 col=2 -> first write address 39048, last 39048+7*80+3=39611;
//    V same block -> first address 58248.
//  3 Clipping: RAM[0]=-5<<16, RAM[1]=300<<16 -> word 0 = 16'h00FF;
//    RAM[2]=32'hFFFFFFFF, RAM[3]=255<<16 -> word 1 = 16'h00FF.
//  4 Start pulsed again 10 cycles after the first -> ignored; done pulses once, 35 cycles
//    after the first start; busy high for cycles 1..35.
//  5 Resetn low during the 10th write -> SRAM_we_n=1 at once, no further writes;
//    a new start after release produces a full 32-write block.
//  6 With IDCT_WR_CLIP_COUNT_EN, all RAM=300<<16 -> clip_count=64 at done; next block
//    of in-range data -> clip_count=0.

Source files
------------

// File: rtl/idct_block_writer_if.sv
// Control handshake plus the dual-port RAM and SRAM buses of the IDCT block writer.
// clip_count exists only when IDCT_WR_CLIP_COUNT_EN is defined.
interface idct_block_writer_if;
    logic        start;
    logic [1:0]  plane;
    logic [4:0]  block_row;
    logic [5:0]  block_col;
    logic        busy;
    logic        done;
    logic [5:0]  DP_address_a;
    logic [5:0]  DP_address_b;
    logic [31:0] DP_read_data_a;
    logic [31:0] DP_read_data_b;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
`ifdef IDCT_WR_CLIP_COUNT_EN
    logic [6:0]  clip_count;
`endif

    // master: the block writer; slave: the IDCT core, RAM and SRAM around it
    modport master (
        input  start, plane, block_row, block_col, DP_read_data_a, DP_read_data_b,
        output busy, done, DP_address_a, DP_address_b,
               SRAM_address, SRAM_write_data, SRAM_we_n
`ifdef IDCT_WR_CLIP_COUNT_EN
        , output clip_count
`endif
    );

    modport slave (
        output start, plane, block_row, block_col, DP_read_data_a, DP_read_data_b,
        input  busy, done, DP_address_a, DP_address_b,
               SRAM_address, SRAM_write_data, SRAM_we_n
`ifdef IDCT_WR_CLIP_COUNT_EN
        , input clip_count
`endif
    );
endinterface

// File: rtl/idct_block_writer.sv
// Reads one 8x8 block of IDCT results, scales/clips to 8 bits, writes 32 packed words
// to the Y/U/V region of SRAM. Optional clip counter: define IDCT_WR_CLIP_COUNT_EN.
module idct_block_writer #(
    parameter int unsigned SHIFT     = 16,
    parameter int unsigned Y_BASE    = 0,
    parameter int unsigned U_BASE    = 38400,
    parameter int unsigned V_BASE    = 57600,
    parameter int unsigned Y_STRIDE  = 160,
    parameter int unsigned UV_STRIDE = 80
) (
    input logic                 Clock,
    input logic                 Resetn,
    idct_block_writer_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_LI0, S_LI1, S_WRITE, S_DONE} state_t;

    state_t      state, state_next;
    logic [1:0]  plane_q;
    logic [4:0]  row_q;
    logic [5:0]  col_q;
    logic [4:0]  k;
    logic        accept, issue, write_en;
    logic [4:0]  pair;
    logic [17:0] base, stride, row_index, word_address;
    logic [7:0]  pix_even, pix_odd;

    function automatic logic [7:0] scale_clip(input logic [31:0] data);
        logic signed [31:0] v;
        v = $signed(data) >>> SHIFT;
        if (v < 0)        return 8'h00;
        else if (v > 255) return 8'hFF;
        else              return v[7:0];
    endfunction

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        write_en   = 1'b0;
        pair       = '0;
        unique case (state)
            S_IDLE: if (bus.start) begin
                accept     = 1'b1;
                state_next = S_LI0;
            end
            S_LI0: begin
                issue      = 1'b1;
                state_next = S_LI1;
            end
            S_LI1: begin
                issue      = 1'b1;
                pair       = 5'd1;
                state_next = S_WRITE;
            end
            S_WRITE: begin
                write_en = 1'b1;
                issue    = (k < 5'd30);
                pair     = k + 5'd2;
                if (k == 5'd31) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Word k uses samples 2k and 2k+1: row k>>2, quad k&3 of the block.
    always_comb begin
        unique case (plane_q)
            2'd0:    begin base = 18'(Y_BASE); stride = 18'(Y_STRIDE);  end
            2'd1:    begin base = 18'(U_BASE); stride = 18'(UV_STRIDE); end
            default: begin base = 18'(V_BASE); stride = 18'(UV_STRIDE); end
        endcase
        row_index    = 18'({row_q, 3'b000}) + 18'(k[4:2]);
        word_address = base + row_index * stride + 18'({col_q, 2'b00}) + 18'(k[1:0]);
        pix_even     = scale_clip(bus.DP_read_data_a);
        pix_odd      = scale_clip(bus.DP_read_data_b);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            plane_q             <= '0;
            row_q               <= '0;
            col_q               <= '0;
            k                   <= '0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.DP_address_a    <= '0;
            bus.DP_address_b    <= '0;
            bus.SRAM_address    <= '0;
            bus.SRAM_write_data <= '0;
            bus.SRAM_we_n       <= 1'b1;
        end else begin
            bus.busy      <= (state != S_IDLE);
            bus.done      <= (state == S_DONE);
            bus.SRAM_we_n <= ~write_en;
            if (accept) begin
                plane_q <= bus.plane;
                row_q   <= bus.block_row;
                col_q   <= bus.block_col;
                k       <= '0;
            end
            if (issue) begin
                bus.DP_address_a <= {pair, 1'b0};
                bus.DP_address_b <= {pair, 1'b1};
            end
            if (write_en) begin
                bus.SRAM_address    <= word_address;
                bus.SRAM_write_data <= {pix_even, pix_odd};
                k                   <= k + 5'd1;
            end
        end
    end

`ifdef IDCT_WR_CLIP_COUNT_EN
    function automatic logic is_clipped(input logic [31:0] data);
        logic signed [31:0] v;
        v = $signed(data) >>> SHIFT;
        return (v < 0) || (v > 255);
    endfunction

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)       bus.clip_count <= '0;
        else if (accept)   bus.clip_count <= '0;
        else if (write_en) bus.clip_count <= bus.clip_count
                                             + 7'(is_clipped(bus.DP_read_data_a))
                                             + 7'(is_clipped(bus.DP_read_data_b));
    end
`endif
endmodule

// File: tb/tb_idct_block_writer.sv
// Directed, table-driven bench for idct_block_writer with a behavioural RAM and SRAM monitor.
module tb_idct_block_writer;
    logic Clock;
    logic Resetn;

    idct_block_writer_if bus ();

    idct_block_writer dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    logic [31:0] ram [64];
    always @(posedge Clock) begin
        bus.DP_read_data_a <= ram[bus.DP_address_a];
        bus.DP_read_data_b <= ram[bus.DP_address_b];
    end

    logic [17:0] wr_addr [$];
    logic [15:0] wr_data [$];
    logic [15:0] sram_mem [int];
    always @(negedge Clock) begin
        if (bus.SRAM_we_n === 1'b0) begin
            wr_addr.push_back(bus.SRAM_address);
            wr_data.push_back(bus.SRAM_write_data);
            sram_mem[int'(bus.SRAM_address)] = bus.SRAM_write_data;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] addr_at(input int i);
        return (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] data_at(input int i);
        return (i < wr_data.size()) ? 32'(wr_data[i]) : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] mem_at(input int a);
        return sram_mem.exists(a) ? 32'(sram_mem[a]) : 32'hDEADBEEF;
    endfunction

    task automatic fill_ram(input int pattern);
        for (int n = 0; n < 64; n++) ram[n] = (pattern == 2) ? 32'h012C0000 : 32'(n) << 16;
        if (pattern == 1) begin
            ram[0]  = 32'hFFFB0000;  // -5
            ram[1]  = 32'h012C0000;  // 300
            ram[2]  = 32'hFFFFFFFF;  // -1 after shift
            ram[3]  = 32'h00FF0000;  // 255, not clipped
            ram[4]  = 32'h0000FFFF;  // 0, not clipped
            ram[5]  = 32'h01000000;  // 256
            ram[62] = 32'h7FFFFFFF;
            ram[63] = 32'h80000000;
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        sram_mem.delete();
    endtask

    // Pulses start for one edge, then waits (bounded) for done; cycle n = after the n-th edge.
    task automatic run_block(input logic [1:0] p, input logic [4:0] r, input logic [5:0] c,
                             output int done_cycle);
        clear_log();
        @(negedge Clock);
        bus.start = 1'b1; bus.plane = p; bus.block_row = r; bus.block_col = c;
        @(negedge Clock);
        bus.start  = 1'b0;
        done_cycle = -1;
        for (int cyc = 1; cyc <= 60 && done_cycle < 0; cyc++) begin
            @(negedge Clock);
            if (bus.done === 1'b1) done_cycle = cyc;
        end
    endtask

    typedef struct {
        logic [1:0]  plane;
        logic [4:0]  row;
        logic [5:0]  col;
        int          pattern;
        logic [17:0] first_addr;
        logic [17:0] last_addr;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] wlast;
        int          clips;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int done_cycle;
        int first_we, last_we, done_n, done_at, busy_err;

        vecs[0] = '{2'd0, 5'd0,  6'd0,  0, 18'd0,     18'd1123,  16'h0001, 16'h0203, 16'h3E3F, 0};
        vecs[1] = '{2'd1, 5'd1,  6'd2,  0, 18'd39048, 18'd39611, 16'h0001, 16'h0203, 16'h3E3F, 0};
        vecs[2] = '{2'd2, 5'd1,  6'd2,  0, 18'd58248, 18'd58811, 16'h0001, 16'h0203, 16'h3E3F, 0};
        vecs[3] = '{2'd3, 5'd1,  6'd2,  0, 18'd58248, 18'd58811, 16'h0001, 16'h0203, 16'h3E3F, 0};
        vecs[4] = '{2'd0, 5'd31, 6'd63, 0, 18'd39932, 18'd41055, 16'h0001, 16'h0203, 16'h3E3F, 0};
        vecs[5] = '{2'd0, 5'd0,  6'd0,  1, 18'd0,     18'd1123,  16'h00FF, 16'h00FF, 16'hFF00, 6};
        vecs[6] = '{2'd1, 5'd0,  6'd0,  2, 18'd38400, 18'd38963, 16'hFFFF, 16'hFFFF, 16'hFFFF, 64};
        vecs[7] = '{2'd0, 5'd0,  6'd0,  0, 18'd0,     18'd1123,  16'h0001, 16'h0203, 16'h3E3F, 0};

        Resetn = 1'b0;
        bus.start = 1'b0; bus.plane = '0; bus.block_row = '0; bus.block_col = '0;
        fill_ram(0);
        repeat (3) @(negedge Clock);
        check("reset_busy",  32'(bus.busy), 32'd0);
        check("reset_done",  32'(bus.done), 32'd0);
        check("reset_we_n",  32'(bus.SRAM_we_n), 32'd1);
        check("reset_addr",  32'(bus.SRAM_address), 32'd0);
        check("reset_data",  32'(bus.SRAM_write_data), 32'd0);
        check("reset_dp_a",  32'(bus.DP_address_a), 32'd0);
        check("reset_dp_b",  32'(bus.DP_address_b), 32'd0);
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);

        for (int i = 0; i < 8; i++) begin
            fill_ram(vecs[i].pattern);
            run_block(vecs[i].plane, vecs[i].row, vecs[i].col, done_cycle);
            check($sformatf("v%0d_done_cycle", i), done_cycle, 35);
            check($sformatf("v%0d_writes", i), wr_addr.size(), 32);
            check($sformatf("v%0d_first_addr", i), addr_at(0), 32'(vecs[i].first_addr));
            check($sformatf("v%0d_last_addr", i), addr_at(31), 32'(vecs[i].last_addr));
            check($sformatf("v%0d_word0", i), data_at(0), 32'(vecs[i].w0));
            check($sformatf("v%0d_word1", i), data_at(1), 32'(vecs[i].w1));
            check($sformatf("v%0d_word31", i), data_at(31), 32'(vecs[i].wlast));
`ifdef IDCT_WR_CLIP_COUNT_EN
            check($sformatf("v%0d_clip_count", i), 32'(bus.clip_count), vecs[i].clips);
`endif
            if (i == 0) begin
                check("y00_sram0",    mem_at(0),    32'h0001);
                check("y00_sram1",    mem_at(1),    32'h0203);
                check("y00_sram3",    mem_at(3),    32'h0607);
                check("y00_sram160",  mem_at(160),  32'h0809);
                check("y00_sram1123", mem_at(1123), 32'h3E3F);
            end
            if (i == 5) check("clip_word2", data_at(2), 32'h00FF);
        end

        // start re-pulsed while busy (edge 10) and in DONE (edge 35) must be ignored
        fill_ram(0);
        clear_log();
        @(negedge Clock);
        bus.start = 1'b1; bus.plane = 2'd0; bus.block_row = '0; bus.block_col = '0;
        @(negedge Clock);
        bus.start = 1'b0;
        check("t4_busy_c0", 32'(bus.busy), 32'd0);
        first_we = -1; last_we = -1; done_n = 0; done_at = -1; busy_err = 0;
        for (int c = 1; c <= 45; c++) begin
            bus.start = (c == 10 || c == 35);
            @(negedge Clock);
            if (bus.SRAM_we_n === 1'b0) begin
                if (first_we < 0) first_we = c;
                last_we = c;
            end
            if (bus.done === 1'b1) begin
                done_n++;
                done_at = c;
            end
            if (bus.busy !== (c <= 35)) busy_err++;
        end
        bus.start = 1'b0;
        check("t4_first_we", first_we, 3);
        check("t4_last_we",  last_we, 34);
        check("t4_done_at",  done_at, 35);
        check("t4_done_n",   done_n, 1);
        check("t4_busy_err", busy_err, 0);
        check("t4_writes",   wr_addr.size(), 32);

        // asynchronous reset during the 10th write
        clear_log();
        @(negedge Clock);
        bus.start = 1'b1;
        @(negedge Clock);
        bus.start = 1'b0;
        for (int c = 1; c <= 40 && wr_addr.size() < 10; c++) begin
            @(negedge Clock);
            #1;
        end
        check("t5_reached_10th", wr_addr.size(), 10);
        Resetn = 1'b0;
        #1;
        check("t5_we_n",  32'(bus.SRAM_we_n), 32'd1);
        check("t5_busy",  32'(bus.busy), 32'd0);
        check("t5_addr",  32'(bus.SRAM_address), 32'd0);
        check("t5_dp_a",  32'(bus.DP_address_a), 32'd0);
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
        repeat (5) @(negedge Clock);
        check("t5_no_more_writes", wr_addr.size(), 10);
        run_block(2'd0, 5'd0, 6'd0, done_cycle);
        check("t5_after_done_cycle", done_cycle, 35);
        check("t5_after_writes",     wr_addr.size(), 32);
        check("t5_after_first_addr", addr_at(0), 32'd0);
        check("t5_after_last_data",  data_at(31), 32'h3E3F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
